// File: rtl/drm_sync_fifo_ctrl.sv
// drm_sync_fifo_ctrl: first-word-fall-through FIFO built around an external
// simple-dual-port block RAM with a 1-cycle, unregistered read port. A 2-entry
// output buffer absorbs the RAM read latency so a word can leave every cycle.
module drm_sync_fifo_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int AFULL_THRESH = 4032
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         mem_count, mem_count_nxt;
  logic                  rd_inflight;
  logic [1:0]            ob_count, ob_count_nxt;
  logic [DATA_WIDTH-1:0] ob0, ob1, ob0_nxt, ob1_nxt;
  logic                  push, pop, rd_issue;
  logic [2:0]            ob_occ;

  assign s_ready = !rst && (mem_count != CW'(DEPTH));
  assign push    = s_valid && s_ready;
  assign m_valid = (ob_count != 2'd0);
  assign m_data  = ob0;
  assign pop     = m_valid && m_ready;

  // Slots the output buffer will still be committed to after this cycle's pop;
  // a new read may only be launched if one slot remains for its data.
  assign ob_occ   = {1'b0, ob_count} + {2'b00, rd_inflight} - {2'b00, pop};
  assign rd_issue = !rst && (mem_count != '0) && (ob_occ < 3'd2);

  assign ram_wr_data = s_data;
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_en   = push;
  assign ram_rd_addr = rd_ptr;

  assign level = mem_count + CW'(rd_inflight) + CW'(ob_count);

  // Words resident in RAM: push adds one, read launch removes one.
  always_comb begin
    mem_count_nxt = mem_count;
    case ({push, rd_issue})
      2'b10:   mem_count_nxt = mem_count + CW'(1);
      2'b01:   mem_count_nxt = mem_count - CW'(1);
      default: mem_count_nxt = mem_count;
    endcase
  end

  // Output buffer: shift on pop first, then land returning RAM data in the
  // first free slot so ordering is kept.
  always_comb begin
    ob0_nxt      = ob0;
    ob1_nxt      = ob1;
    ob_count_nxt = ob_count;
    if (pop) begin
      ob0_nxt      = ob1;
      ob_count_nxt = ob_count - 2'd1;
    end
    if (rd_inflight) begin
      if (ob_count_nxt == 2'd0) ob0_nxt = ram_rd_data;
      else                      ob1_nxt = ram_rd_data;
      ob_count_nxt = ob_count_nxt + 2'd1;
    end
  end

  // State update; reset discards everything including a read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_count   <= '0;
      rd_inflight <= 1'b0;
      ob_count    <= 2'd0;
      ob0         <= '0;
      ob1         <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      mem_count   <= mem_count_nxt;
      rd_inflight <= rd_issue;
      ob_count    <= ob_count_nxt;
      ob0         <= ob0_nxt;
      ob1         <= ob1_nxt;
      almost_full <= (mem_count_nxt >= CW'(AFULL_THRESH));
    end
  end

endmodule

// File: tb/tb_drm_sync_fifo_ctrl.sv
// Bench for drm_sync_fifo_ctrl: behavioural RAM, a queue scoreboard, a cycle
// table for reset/latency, then streaming, full/wrap, backpressure and
// mid-stream reset scenarios.
module tb_drm_sync_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [12:0] level;
  logic        almost_full;
  logic [31:0] ram_wr_data;
  logic [11:0] ram_wr_addr;
  logic        ram_wr_en;
  logic [11:0] ram_rd_addr;
  logic [31:0] ram_rd_data;

  drm_sync_fifo_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .AFULL_THRESH(4032)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
    .almost_full(almost_full), .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr),
    .ram_wr_en(ram_wr_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural block RAM: address latched at the edge, data out next cycle.
  logic [31:0] mem [0:4095];
  logic [31:0] rd_q = '0;
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    rd_q <= mem[ram_rd_addr];
  end
  assign ram_rd_data = rd_q;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: the FIFO contents as a plain queue.
  logic [31:0] q[$];
  bit          mon_en = 0;
  bit          stream_mode = 0;
  bit          seen_first = 0;
  int          n_pop = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("level", 64'(level), 64'(q.size()));
      chk("wr_en", 64'(ram_wr_en), 64'(s_valid && s_ready));
      chk("ob_inv", 64'((dut.ob_count + dut.rd_inflight) <= 2), 64'd1);
      if (q.size() < 4096) chk("s_ready_room", 64'(s_ready), 64'd1);
      if (m_valid) chk("m_valid_nonempty", 64'(q.size() > 0), 64'd1);
      if (prev_stall) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_data", 64'(m_data), 64'(prev_data));
      end
      if (stream_mode) begin
        chk("stream_level_le4", 64'(level <= 13'd4), 64'd1);
        if (seen_first && n_pop < 1000) chk("stream_gap", 64'(m_valid), 64'd1);
        if (m_valid) seen_first = 1;
      end
      if (s_valid && s_ready) q.push_back(s_data);
      if (m_valid && m_ready) begin
        if (q.size() == 0) chk("pop_underflow", 64'd1, 64'd0);
        else chk("pop_data", 64'(m_data), 64'(q.pop_front()));
        n_pop++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  // Driver state
  int          n_acc = 0;
  logic [31:0] seq = 32'h1000_0000;
  bit          rnd_data = 0;

  task automatic run(input int ncyc, input int sv_pct, input int mr_pct, input int max_push);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      s_valid = (n_acc < max_push) && (int'($urandom_range(99)) < sv_pct);
      s_data  = rnd_data ? $urandom : seq;
      m_ready = (int'($urandom_range(99)) < mr_pct);
      @(negedge clk);
      if (s_valid && s_ready) begin n_acc++; seq++; end
    end
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while (q.size() > 0 && c < maxc) begin
      run(1, 0, 100, 0);
      c++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  typedef struct packed {
    logic        rst;
    logic        sv;
    logic [31:0] sd;
    logic        mr;
    logic        e_srdy;
    logic        e_wen;
    logic        e_mv;
    logic        e_chkd;
    logic [31:0] e_md;
    logic [12:0] e_lvl;
  } vec_t;

  vec_t tbl [9];

  initial begin
    // Reset with s_valid high, then single-word latency into an empty FIFO.
    tbl[0] = '{1'b1, 1'b1, 32'hDEAD_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 13'd0};
    tbl[1] = '{1'b1, 1'b1, 32'hDEAD_0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 13'd0};
    tbl[2] = '{1'b1, 1'b1, 32'hDEAD_0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 13'd0};
    tbl[3] = '{1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 13'd0};
    tbl[4] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 13'd1};
    tbl[5] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 13'd1};
    tbl[6] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001, 13'd1};
    tbl[7] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 13'd0};
    tbl[8] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 13'd0};

    repeat (2) @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      rst = tbl[i].rst; s_valid = tbl[i].sv; s_data = tbl[i].sd; m_ready = tbl[i].mr;
      @(negedge clk);
      chk($sformatf("t%0d_s_ready", i), 64'(s_ready), 64'(tbl[i].e_srdy));
      chk($sformatf("t%0d_wr_en", i), 64'(ram_wr_en), 64'(tbl[i].e_wen));
      chk($sformatf("t%0d_m_valid", i), 64'(m_valid), 64'(tbl[i].e_mv));
      chk($sformatf("t%0d_level", i), 64'(level), 64'(tbl[i].e_lvl));
      if (tbl[i].e_chkd) chk($sformatf("t%0d_m_data", i), 64'(m_data), 64'(tbl[i].e_md));
      if (i < 3) chk($sformatf("t%0d_afull", i), 64'(almost_full), 64'd0);
    end
    mon_en = 1;

    // Streaming: 1000 words back to back with the consumer always ready.
    stream_mode = 1; seen_first = 0; n_pop = 0; n_acc = 0; rnd_data = 0;
    run(1000, 100, 100, 1000);
    drain(50);
    chk("stream_pops", 64'(n_pop), 64'd1000);
    stream_mode = 0;

    // Fill with consumer stalled; check almost_full threshold edge.
    n_acc = 0;
    run(4033, 100, 0, 4033);
    run(4, 0, 0, 0);
    chk("afull_below", 64'(almost_full), 64'd0);
    chk("level_4033", 64'(level), 64'd4033);
    run(1, 100, 0, 4034);
    run(4, 0, 0, 0);
    chk("afull_at", 64'(almost_full), 64'd1);
    run(100, 100, 0, 100000);
    chk("full_accepted", 64'(n_acc), 64'd4098);
    chk("full_s_ready", 64'(s_ready), 64'd0);
    chk("full_level", 64'(level), 64'd4098);
    chk("full_afull", 64'(almost_full), 64'd1);

    // Drain across pointer wrap while pushing 5000 more random words.
    n_acc = 0; rnd_data = 1;
    run(14000, 40, 70, 5000);
    drain(6000);
    run(3, 0, 0, 0);
    chk("drained_afull", 64'(almost_full), 64'd0);

    // Random backpressure on both sides.
    n_acc = 0;
    run(20000, 50, 50, 1 << 30);
    drain(200);

    // Reset mid-stream with a pop in progress.
    n_acc = 0; rnd_data = 0;
    run(100, 100, 0, 100);
    run(3, 0, 100, 0);
    @(posedge clk); #1;
    mon_en = 0; rst = 1; s_valid = 0; m_ready = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_mid_m_valid", 64'(m_valid), 64'd0);
    chk("rst_mid_level", 64'(level), 64'd0);
    chk("rst_mid_s_ready", 64'(s_ready), 64'd1);
    q.delete(); prev_stall = 0;
    mon_en = 1;
    @(posedge clk); #1;
    s_valid = 1; s_data = 32'h0000_1234; m_ready = 1;
    @(posedge clk); #1;
    s_valid = 0;
    begin
      int c;
      c = 0;
      @(negedge clk);
      while (!m_valid && c < 10) begin @(negedge clk); c++; end
    end
    chk("post_rst_valid", 64'(m_valid), 64'd1);
    chk("post_rst_first", 64'(m_data), 64'h1234);
    run(5, 0, 100, 0);
    chk("post_rst_empty", 64'(level), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
